// File: rtl/decoder_pkg.sv
// Shared opcode map, mux encodings and control bundle
// for the compute-core instruction decoder.
package decoder_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_BRNZP = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_LDR   = 4'b0111;
    localparam logic [3:0] OP_STR   = 4'b1000;
    localparam logic [3:0] OP_CONST = 4'b1001;
    localparam logic [3:0] OP_RET   = 4'b1111;

    localparam logic [1:0] RIM_ALU = 2'b00;
    localparam logic [1:0] RIM_MEM = 2'b01;
    localparam logic [1:0] RIM_IMM = 2'b10;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

    typedef struct packed {
        logic       reg_write_enable;
        logic       mem_read_enable;
        logic       mem_write_enable;
        logic       nzp_write_enable;
        logic [1:0] reg_input_mux;
        logic [1:0] alu_arith_mux;
        logic       alu_output_mux;
        logic       pc_mux;
        logic       ret;
        logic       illegal;
    } ctrl_t;

    // All-zero control set, behaves as a NOP
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/decoder_ctrl_lut.sv
// Combinational opcode to control-vector lookup.
// Unmapped opcodes raise illegal and otherwise act as NOP.
module decoder_ctrl_lut
    import decoder_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    // Decode opcode into its control set; everything defaults low
    always_comb begin
        ctrl = ctrl_nop();
        case (opcode)
            OP_NOP: begin
            end
            OP_BRNZP: begin
                ctrl.pc_mux = 1'b1;
            end
            OP_CMP: begin
                ctrl.alu_output_mux   = 1'b1;
                ctrl.nzp_write_enable = 1'b1;
            end
            OP_ADD: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.reg_input_mux    = RIM_ALU;
                ctrl.alu_arith_mux    = ARITH_ADD;
            end
            OP_SUB: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.reg_input_mux    = RIM_ALU;
                ctrl.alu_arith_mux    = ARITH_SUB;
            end
            OP_MUL: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.reg_input_mux    = RIM_ALU;
                ctrl.alu_arith_mux    = ARITH_MUL;
            end
            OP_DIV: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.reg_input_mux    = RIM_ALU;
                ctrl.alu_arith_mux    = ARITH_DIV;
            end
            OP_LDR: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.mem_read_enable  = 1'b1;
                ctrl.reg_input_mux    = RIM_MEM;
            end
            OP_STR: begin
                ctrl.mem_write_enable = 1'b1;
            end
            OP_CONST: begin
                ctrl.reg_write_enable = 1'b1;
                ctrl.reg_input_mux    = RIM_IMM;
            end
            OP_RET: begin
                ctrl.ret = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decoder.sv
// Instruction decode stage: combinational field slicing
// plus one registered stage of control signals and nzp.
module decoder
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  decode_en,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [3:0]            opcode,
    output logic [3:0]            dest_reg,
    output logic [3:0]            src1_reg,
    output logic [3:0]            src2_reg,
    output logic [7:0]            immediate,
    output logic [2:0]            nzp,
    output logic                  reg_write_enable,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic                  nzp_write_enable,
    output logic [1:0]            reg_input_mux,
    output logic [1:0]            alu_arith_mux,
    output logic                  alu_output_mux,
    output logic                  pc_mux,
    output logic                  ret,
    output logic                  illegal
);

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic [2:0] nzp_q;

    assign opcode    = instruction[15:12];
    assign dest_reg  = instruction[11:8];
    assign src1_reg  = instruction[7:4];
    assign src2_reg  = instruction[3:0];
    assign immediate = instruction[7:0];

    decoder_ctrl_lut u_lut (
        .opcode (instruction[15:12]),
        .ctrl   (ctrl_d)
    );

    // Capture controls and branch mask on each decode; reset clears to NOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= ctrl_nop();
            nzp_q  <= 3'b000;
        end else if (decode_en) begin
            ctrl_q <= ctrl_d;
            nzp_q  <= instruction[11:9];
        end
    end

    assign nzp              = nzp_q;
    assign reg_write_enable = ctrl_q.reg_write_enable;
    assign mem_read_enable  = ctrl_q.mem_read_enable;
    assign mem_write_enable = ctrl_q.mem_write_enable;
    assign nzp_write_enable = ctrl_q.nzp_write_enable;
    assign reg_input_mux    = ctrl_q.reg_input_mux;
    assign alu_arith_mux    = ctrl_q.alu_arith_mux;
    assign alu_output_mux   = ctrl_q.alu_output_mux;
    assign pc_mux           = ctrl_q.pc_mux;
    assign ret              = ctrl_q.ret;
    assign illegal          = ctrl_q.illegal;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed words, hold,
// async reset and randomized traffic against a reference model.
module tb_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        decode_en;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic [3:0]  dest_reg;
    logic [3:0]  src1_reg;
    logic [3:0]  src2_reg;
    logic [7:0]  immediate;
    logic [2:0]  nzp;
    logic        reg_write_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic        nzp_write_enable;
    logic [1:0]  reg_input_mux;
    logic [1:0]  alu_arith_mux;
    logic        alu_output_mux;
    logic        pc_mux;
    logic        ret;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    // model of registered outputs: {nzp, rwe, mre, mwe, nwe, rim, aam, aom, pcm, ret, ill}
    logic [14:0] model;

    always #5 clk = ~clk;

    decoder #(.DATA_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .decode_en        (decode_en),
        .instruction      (instruction),
        .opcode           (opcode),
        .dest_reg         (dest_reg),
        .src1_reg         (src1_reg),
        .src2_reg         (src2_reg),
        .immediate        (immediate),
        .nzp              (nzp),
        .reg_write_enable (reg_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .nzp_write_enable (nzp_write_enable),
        .reg_input_mux    (reg_input_mux),
        .alu_arith_mux    (alu_arith_mux),
        .alu_output_mux   (alu_output_mux),
        .pc_mux           (pc_mux),
        .ret              (ret),
        .illegal          (illegal)
    );

    // Controls from the opcode table, expressed as opcode ranges
    function automatic logic [11:0] spec_ctrl(input logic [3:0] op);
        int o;
        logic rwe, mre, mwe, nwe, aom, pcm, rt, ill;
        logic [1:0] rim, aam;
        o   = int'(op);
        ill = (o >= 10 && o <= 14);
        rt  = (o == 15);
        pcm = (o == 1);
        aom = (o == 2);
        nwe = (o == 2);
        rwe = (o >= 3 && o <= 7) || (o == 9);
        mre = (o == 7);
        mwe = (o == 8);
        rim = (o == 7) ? 2'd1 : (o == 9) ? 2'd2 : 2'd0;
        aam = (o >= 3 && o <= 6) ? 2'(o - 3) : 2'd0;
        return {rwe, mre, mwe, nwe, rim, aam, aom, pcm, rt, ill};
    endfunction

    function automatic logic [14:0] obs_regs();
        return {nzp, reg_write_enable, mem_read_enable,
                mem_write_enable, nzp_write_enable,
                reg_input_mux, alu_arith_mux,
                alu_output_mux, pc_mux, ret, illegal};
    endfunction

    function automatic logic [23:0] obs_fields();
        return {opcode, dest_reg, src1_reg, src2_reg, immediate};
    endfunction

    task automatic apply(input logic [15:0] w, input logic en);
        @(negedge clk);
        instruction = w;
        decode_en   = en;
    endtask

    // Advance one edge and update the model, then settle
    task automatic tick();
        @(posedge clk);
        if (reset)
            model = '0;
        else if (decode_en)
            model = {instruction[11:9], spec_ctrl(instruction[15:12])};
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        decode_en   = 1'b0;
        instruction = 16'h0000;
        model       = '0;
        repeat (2) tick();
        checks++;
        if (obs_regs() !== 15'd0) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs_regs(), 15'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (obs_regs() !== 15'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=%b", obs_regs(), 15'd0);
        end
    endtask

    task automatic test_directed();
        logic [15:0] words [5];
        logic [23:0] flds  [5];
        logic [14:0] regs  [5];
        words[0] = 16'h1AC3; flds[0] = 24'h1AC3C3; regs[0] = 15'b101_0000_00_00_0_1_0_0;
        words[1] = 16'h9567; flds[1] = 24'h956767; regs[1] = 15'b010_1000_10_00_0_0_0_0;
        words[2] = 16'h6F12; flds[2] = 24'h6F1212; regs[2] = 15'b111_1000_00_11_0_0_0_0;
        words[3] = 16'hE08F; flds[3] = 24'hE08F8F; regs[3] = 15'b000_0000_00_00_0_0_0_1;
        words[4] = 16'hF000; flds[4] = 24'hF00000; regs[4] = 15'b000_0000_00_00_0_0_1_0;
        for (int i = 0; i < 5; i++) begin
            apply(words[i], 1'b1);
            #1;
            checks++;
            if (obs_fields() !== flds[i]) begin
                failures++;
                $display("FAIL dir_fields[%0d] got=%h want=%h", i, obs_fields(), flds[i]);
            end
            tick();
            checks++;
            if (obs_regs() !== regs[i]) begin
                failures++;
                $display("FAIL dir_ctrl[%0d] got=%b want=%b", i, obs_regs(), regs[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [14:0] add_regs;
        add_regs = 15'b000_1000_00_00_0_0_0_0;
        apply(16'h3123, 1'b1);
        tick();
        checks++;
        if (obs_regs() !== add_regs) begin
            failures++;
            $display("FAIL hold_load got=%b want=%b", obs_regs(), add_regs);
        end
        apply(16'h7123, 1'b0);
        #1;
        checks++;
        if (obs_fields() !== 24'h712323) begin
            failures++;
            $display("FAIL hold_fields got=%h want=%h", obs_fields(), 24'h712323);
        end
        repeat (3) begin
            tick();
            checks++;
            if (obs_regs() !== add_regs) begin
                failures++;
                $display("FAIL hold_ctrl got=%b want=%b", obs_regs(), add_regs);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(16'h6F12, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        model = '0;
        checks++;
        if (obs_regs() !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", obs_regs(), 15'd0);
        end
        apply(16'hF000, 1'b1);
        tick();
        checks++;
        if (obs_regs() !== 15'd0) begin
            failures++;
            $display("FAIL reset_dominates got=%b want=%b", obs_regs(), 15'd0);
        end
        @(negedge clk);
        reset     = 1'b0;
        decode_en = 1'b0;
        tick();
        checks++;
        if (obs_regs() !== 15'd0) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs_regs(), 15'd0);
        end
        apply(16'h2E00, 1'b1);
        tick();
        checks++;
        if (obs_regs() !== 15'b111_0001_00_00_1_0_0_0) begin
            failures++;
            $display("FAIL first_decode got=%b want=%b", obs_regs(), 15'b111_0001_00_00_1_0_0_0);
        end
    endtask

    task automatic test_back_to_back();
        for (int op = 0; op < 16; op++) begin
            logic [15:0] w;
            w = {4'(op), 12'($urandom)};
            apply(w, 1'b1);
            tick();
            checks++;
            if (obs_regs() !== model) begin
                failures++;
                $display("FAIL b2b op=%0d got=%b want=%b", op, obs_regs(), model);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            apply(w, 1'($urandom_range(0, 1)));
            #1;
            checks++;
            if (obs_fields() !== {w, w[7:0]}) begin
                failures++;
                $display("FAIL rand_fields w=%h got=%h want=%h", w, obs_fields(), {w, w[7:0]});
            end
            tick();
            checks++;
            if (obs_regs() !== model) begin
                failures++;
                $display("FAIL rand_ctrl w=%h got=%b want=%b", w, obs_regs(), model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder.md
# decoder

Instruction decode stage of the Small GPU compute core. It splits a 16-bit instruction into opcode, register-index and immediate fields, and produces registered control signals for the ALU, LSU, register file, NZP and PC units. It sits between instruction fetch and the per-thread execution units. One instance is shared by all threads of a core.

## Interface
- DATA_WIDTH, 16: instruction width; only 16 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- decode_en  in  1  when high, control outputs load from `instruction` at the next rising edge.
- instruction  in  16  instruction word.
- opcode  out  4  instruction[15:12], combinational.
- dest_reg  out  4  instruction[11:8], combinational.
- src1_reg  out  4  instruction[7:4], combinational.
- src2_reg  out  4  instruction[3:0], combinational.
- immediate  out  8  instruction[7:0], combinational.
- nzp  out  3  registered instruction[11:9]; branch condition mask.
- reg_write_enable  out  1  registered; register-file write.
- mem_read_enable  out  1  registered; LSU load.
- mem_write_enable  out  1  registered; LSU store.
- nzp_write_enable  out  1  registered; NZP register update.
- reg_input_mux  out  2  registered; 00 ALU, 01 memory, 10 immediate.
- alu_arith_mux  out  2  registered; 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- alu_output_mux  out  1  registered; 1 selects compare result.
- pc_mux  out  1  registered; 1 selects branch target.
- ret  out  1  registered; thread done.
- illegal  out  1  registered; unassigned opcode.

## Operation
- Field outputs are pure bit slices of `instruction`. They follow it continuously, with no clock or reset dependence.
- Opcode map and asserted controls (all other controls are 0):
  - 0000 NOP: none.
  - 0001 BRnzp: pc_mux.
  - 0010 CMP: alu_output_mux, nzp_write_enable.
  - 0011 ADD, 0100 SUB, 0101 MUL, 0110 DIV: reg_write_enable, reg_input_mux=00, alu_arith_mux=00/01/10/11 respectively.
  - 0111 LDR: reg_write_enable, mem_read_enable, reg_input_mux=01.
  - 1000 STR: mem_write_enable.
  - 1001 CONST: reg_write_enable, reg_input_mux=10.
  - 1111 RET: ret.
  - 1010 to 1110: illegal=1, all other controls 0 (executes as NOP).
- nzp loads instruction[11:9] on every decode, whatever the opcode.

## Timing
- Control latency is one cycle. Controls update at the first rising clk where decode_en=1.
- decode_en=0: all registered outputs hold their values.
- Back-to-back decode_en: a new control set every cycle, with no bubbles.
- reset asserted, asynchronously: every registered output goes to 0 immediately, whatever clk or decode_en is doing. The result is NOP-equivalent, with nzp=000 and illegal=0.
- reset deasserted: registers stay 0 until the first edge with decode_en=1.
- reset dominates decode_en at a shared edge.
- No X propagation: an opcode outside the map yields the illegal response, never an undefined control.

## Structure
- decoder_pkg holds:
  - opcode localparams: OP_NOP through OP_RET.
  - reg_input_mux encodings.
  - alu_arith_mux encodings.
  - a packed control-vector type.
- One sub-module, decoder_ctrl_lut: a purely combinational opcode-to-control-vector case statement. Its default branch sets illegal.
- Top level: field slicing, plus a single async-reset register stage on the control vector and nzp.

## Test plan
- Reset: assert reset mid-cycle while controls are nonzero. All registered outputs read 0 before the next clk edge.
- 0x1AC3 with decode_en:
  - fields immediately: opcode=1, dest=A, src1=C, src2=3, imm=C3.
  - after one edge: pc_mux=1, nzp=101, all else 0.
- 0x9567 (CONST):
  - fields: 9/5/6/7, imm=67.
  - after one edge: reg_write_enable=1, reg_input_mux=10.
- 0x6F12 (DIV):
  - fields: 6/F/1/2, imm=12.
  - controls: reg_write_enable=1, reg_input_mux=00, alu_arith_mux=11.
- 0xE08F:
  - fields: E/0/8/F, imm=8F.
  - controls: illegal=1, all enables 0.
  - then 0xF000 gives ret=1, illegal=0.
- Hold: apply 0x7123 with decode_en=0 after the ADD word 0x3123. Controls keep the ADD values, while the fields show 7/1/2/3 at once.
